thumb_fetch_queue: RTL and testbench

Sits directly downstream of program_counter and the synchronous instruction memory, upstream of decode. Pairs each returned 16-bit halfword with the PC that requested it, drops duplicates from stall-held PCs, and buffers halfwords in a small queue. Assembles Thumb-2 32-bit instructions from two halfwords and presents whole instructions to decode with a valid/ready handshake. Drives a stall request back to the PC so no fetched halfword is lost. Flushes on redirect (branch taken or branch from WB).

---
 rtl/thumb_fetch_queue.sv | 122 ++++++++++++
 tb/tb_thumb_fetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/thumb_fetch_queue.sv
// Fetch queue between instruction memory and decode: pairs halfwords with their PCs and
// assembles 16/32-bit Thumb instructions. Define FETCH_THUMB32_EN to enable 32-bit assembly.
module thumb_fetch_queue #(
   parameter int WORD  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [WORD-1:0] pc_i,
   input  logic            pc_valid_i,
   input  logic [15:0]     imem_halfword_i,
   input  logic            redirect_i,
   input  logic [WORD-1:0] redirect_pc_i,
   input  logic            decode_ready_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [WORD-1:0] instr_pc_o,
   output logic            instr_is_32_o,
   output logic            stall_req_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 2);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] TWO_C   = CW'(2);

   logic [15:0]     hw_mem_q [DEPTH];
   logic [WORD-1:0] pc_mem_q [DEPTH];

   logic [WORD-1:0] req_pc_q, req_pc_d;
   logic            req_valid_q, req_valid_d;
   logic [WORD-1:0] expected_pc_q, expected_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

   logic [AW-1:0]   rd_ptr_nxt;
   logic [15:0]     head_hw;
   logic [15:0]     second_hw;
   logic            head_32;
   logic            head_ok;
   logic            push;
   logic            pop;

   assign rd_ptr_nxt = rd_ptr_q + AW'(1);
   assign head_hw    = hw_mem_q[rd_ptr_q];
   assign second_hw  = hw_mem_q[rd_ptr_nxt];

`ifdef FETCH_THUMB32_EN
   assign head_32 = (head_hw[15:11] == 5'b11101) || (head_hw[15:11] == 5'b11110) ||
                    (head_hw[15:11] == 5'b11111);
`else
   assign head_32 = 1'b0;
`endif

   // A 32-bit head needs both halves resident before it is presented.
   assign head_ok       = (count_q >= ONE_C) && (!head_32 || (count_q >= TWO_C));
   assign instr_valid_o = head_ok && !redirect_i;
   assign instr_is_32_o = instr_valid_o && head_32;
   assign instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
   assign instr_o       = !instr_valid_o ? 32'h0 :
                          head_32 ? {head_hw, second_hw} : {16'h0, head_hw};
   assign stall_req_o   = (count_q >= STALL_C);

   // Only the halfword we are waiting for is kept; stall repeats and stale returns fall away.
   assign push = req_valid_q && (req_pc_q == expected_pc_q) && (count_q < FULL_C) && !redirect_i;
   assign pop  = instr_valid_o && decode_ready_i;

   always_comb begin
      req_pc_d      = pc_i;
      req_valid_d   = pc_valid_i;
      expected_pc_d = expected_pc_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      if (redirect_i) begin
         req_valid_d   = 1'b0;
         expected_pc_d = redirect_pc_i;
         count_d       = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
      end else begin
         if (push) begin
            wr_ptr_d      = wr_ptr_q + AW'(1);
            expected_pc_d = expected_pc_q + WORD'(2);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + (head_32 ? AW'(2) : AW'(1));
         end
         count_d = count_q + (push ? ONE_C : '0) - (pop ? (head_32 ? TWO_C : ONE_C) : '0);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         req_pc_q      <= '0;
         req_valid_q   <= 1'b0;
         expected_pc_q <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         req_pc_q      <= req_pc_d;
         req_valid_q   <= req_valid_d;
         expected_pc_q <= expected_pc_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; occupancy is governed by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         hw_mem_q[wr_ptr_q] <= imem_halfword_i;
         pc_mem_q[wr_ptr_q] <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_thumb_fetch_queue.sv
// Directed bench for thumb_fetch_queue: a one-cycle imem model feeds halfwords while each
// cycle's outputs are compared with hand-computed values (both FETCH_THUMB32_EN builds).
module tb_thumb_fetch_queue;

   logic        clk_i;
   logic        reset_i;
   logic [31:0] pc_i;
   logic        pc_valid_i;
   logic [15:0] imem_halfword_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        decode_ready_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_is_32_o;
   logic        stall_req_o;

   int n_checks = 0;
   int n_fail   = 0;

   thumb_fetch_queue #(.WORD(32), .DEPTH(4)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .pc_i            (pc_i),
      .pc_valid_i      (pc_valid_i),
      .imem_halfword_i (imem_halfword_i),
      .redirect_i      (redirect_i),
      .redirect_pc_i   (redirect_pc_i),
      .decode_ready_i  (decode_ready_i),
      .instr_valid_o   (instr_valid_o),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_is_32_o   (instr_is_32_o),
      .stall_req_o     (stall_req_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] imem_f(input logic [31:0] a);
      case (a)
         32'h0:   return 16'h2001;
         32'h2:   return 16'h2102;
         32'h4:   return 16'h1888;
         32'h6:   return 16'h4770;
         32'h8:   return 16'hF000;
         32'hA:   return 16'hF800;
         default: return {8'h20, a[7:0]};
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [31:0] v, input logic [31:0] ins,
                             input logic [31:0] ipc, input logic [31:0] is32,
                             input logic [31:0] stall);
      check_val({tag, "_valid"}, 32'(instr_valid_o), v);
      check_val({tag, "_instr"}, instr_o, ins);
      check_val({tag, "_pc"}, instr_pc_o, ipc);
      check_val({tag, "_is32"}, 32'(instr_is_32_o), is32);
      check_val({tag, "_stall"}, 32'(stall_req_o), stall);
   endtask

   // Synchronous imem: the halfword for the address presented this cycle appears next cycle.
   task automatic step();
      logic [31:0] p;
      p = pc_i;
      @(posedge clk_i);
      #1;
      imem_halfword_i = imem_f(p);
   endtask

   task automatic cyc(input logic [31:0] pc, input logic pv, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input string tag, input logic [31:0] v,
                      input logic [31:0] ins, input logic [31:0] ipc, input logic [31:0] is32,
                      input logic [31:0] stall);
      pc_i           = pc;
      pc_valid_i     = pv;
      decode_ready_i = rdy;
      redirect_i     = redir;
      redirect_pc_i  = rpc;
      #1;
      expect_out(tag, v, ins, ipc, is32, stall);
      if (instr_valid_o && decode_ready_i)
         $display("xfer %s pc=%h instr=%h is32=%0d", tag, instr_pc_o, instr_o, instr_is_32_o);
      step();
   endtask

   initial begin
      reset_i         = 1'b1;
      pc_i            = 32'h0;
      pc_valid_i      = 1'b0;
      imem_halfword_i = 16'h0;
      redirect_i      = 1'b0;
      redirect_pc_i   = 32'h0;
      decode_ready_i  = 1'b0;
      #1;
      expect_out("reset", 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // Straight-line 16-bit stream, one instruction per cycle after a two-cycle fill.
      cyc(32'h00, 1, 1, 0, 0, "c0", 0, 0, 0, 0, 0);
      cyc(32'h02, 1, 1, 0, 0, "c1", 0, 0, 0, 0, 0);
      cyc(32'h04, 1, 1, 0, 0, "c2", 1, 32'h00002001, 32'h0, 0, 0);
      cyc(32'h06, 1, 1, 0, 0, "c3", 1, 32'h00002102, 32'h2, 0, 0);
      cyc(32'h08, 1, 1, 0, 0, "c4", 1, 32'h00001888, 32'h4, 0, 0);
      cyc(32'h0A, 1, 1, 0, 0, "c5", 1, 32'h00004770, 32'h6, 0, 0);
`ifdef FETCH_THUMB32_EN
      cyc(32'h0C, 1, 1, 0, 0, "c6_half", 0, 0, 0, 0, 0);
      cyc(32'h0E, 1, 1, 0, 0, "c7_t32", 1, 32'hF000F800, 32'h8, 1, 1);
`else
      cyc(32'h0C, 1, 1, 0, 0, "c6_t16", 1, 32'h0000F000, 32'h8, 0, 0);
      cyc(32'h0E, 1, 1, 0, 0, "c7_t16", 1, 32'h0000F800, 32'hA, 0, 0);
`endif
      // PC held at 0x10 for three cycles: its halfword must be queued once.
      cyc(32'h10, 1, 1, 0, 0, "c8", 1, 32'h0000200C, 32'hC, 0, 0);
      cyc(32'h10, 1, 1, 0, 0, "c9", 1, 32'h0000200E, 32'hE, 0, 0);
      cyc(32'h10, 1, 1, 0, 0, "c10", 1, 32'h00002010, 32'h10, 0, 0);
      cyc(32'h12, 1, 1, 0, 0, "c11_nodup", 0, 0, 0, 0, 0);
      cyc(32'h14, 1, 1, 0, 0, "c12", 0, 0, 0, 0, 0);

      // Decode stalled: queue fills to DEPTH; a matching return while full is refused.
      cyc(32'h16, 1, 0, 0, 0, "c13", 1, 32'h00002012, 32'h12, 0, 0);
      cyc(32'h18, 1, 0, 0, 0, "c14_stall", 1, 32'h00002012, 32'h12, 0, 1);
      cyc(32'h18, 1, 0, 0, 0, "c15", 1, 32'h00002012, 32'h12, 0, 1);
      cyc(32'h1A, 1, 0, 0, 0, "c16", 1, 32'h00002012, 32'h12, 0, 1);
      cyc(32'h1A, 1, 0, 0, 0, "c17_full", 1, 32'h00002012, 32'h12, 0, 1);
      cyc(32'h1A, 1, 1, 0, 0, "c18", 1, 32'h00002012, 32'h12, 0, 1);
      cyc(32'h1C, 1, 1, 0, 0, "c19", 1, 32'h00002014, 32'h14, 0, 1);
      cyc(32'h1E, 1, 1, 0, 0, "c20", 1, 32'h00002016, 32'h16, 0, 1);
      cyc(32'h20, 1, 1, 0, 0, "c21", 1, 32'h00002018, 32'h18, 0, 1);

      // Redirect with three entries queued; stale returns afterwards are ignored.
      cyc(32'h22, 1, 1, 1, 32'h40, "c22_redir", 0, 0, 0, 0, 1);
      cyc(32'h24, 1, 1, 0, 0, "c23", 0, 0, 0, 0, 0);
      cyc(32'h40, 1, 1, 0, 0, "c24_stale", 0, 0, 0, 0, 0);
      cyc(32'h42, 1, 1, 0, 0, "c25", 0, 0, 0, 0, 0);
      cyc(32'h44, 1, 0, 0, 0, "c26", 1, 32'h00002040, 32'h40, 0, 0);

      // Asynchronous reset with two entries queued.
      pc_i           = 32'h46;
      pc_valid_i     = 1'b1;
      decode_ready_i = 1'b0;
      #1;
      expect_out("c27_pre", 1, 32'h00002040, 32'h40, 0, 1);
      #1;
      reset_i = 1'b1;
      #1;
      expect_out("c27_async_rst", 0, 0, 0, 0, 0);
      @(posedge clk_i);
      #1;
      pc_i       = 32'h0;
      pc_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      cyc(32'h00, 1, 1, 0, 0, "r0", 0, 0, 0, 0, 0);
      cyc(32'h02, 1, 1, 0, 0, "r1", 0, 0, 0, 0, 0);
      cyc(32'h04, 1, 1, 0, 0, "r2", 1, 32'h00002001, 32'h0, 0, 0);
      cyc(32'h06, 1, 1, 0, 0, "r3", 1, 32'h00002102, 32'h2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
